ram_sync_pipe: RTL and testbench



---
 rtl/ram_sync_pipe.sv | 144 ++++++++++++++
 tb/tb_ram_sync_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_pipe.sv
// rtl/ram_sync_pipe.sv - single-port synchronous RAM with clear sweep, valid/ready requests, byte enables
// Optional macro RAM_ADDR_CHECK_EN: drives rsp_err and builds the saturating err_count register.
module ram_sync_pipe #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 128,
    parameter int ADDR_W         = 7,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   sweep_q;
    logic                req_ready_q;
    logic                busy_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                in_range;
    logic [DATA_W-1:0]   rd_word_d;
    logic [DATA_W-1:0]   merged_d;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                err_d;

    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] err_q;
    logic [DATA_W-1:0]       dat_q [READ_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            sweep_q     <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                CLEAR: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == LAST_ADDR) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign accept   = req_valid && req_ready_q && !reset;
    assign in_range = {1'b0, req_addr} < DEPTH_X;

    // Out-of-range requests read as zero and never merge write data into the response.
    always_comb begin
        rd_word_d = '0;
        if (in_range) rd_word_d = mem[req_addr];
        merged_d = rd_word_d;
        for (int b = 0; b < NB; b++) begin
            if (req_be[b]) merged_d[8*b +: 8] = req_wdata[8*b +: 8];
        end
        rsp_data_d = '0;
        if (in_range) rsp_data_d = req_we ? merged_d : rd_word_d;
    end

`ifdef RAM_ADDR_CHECK_EN
    assign err_d = !in_range;
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[sweep_q] <= '0;
            end else if (accept && req_we && in_range) begin
                mem[req_addr] <= merged_d;
            end
        end
    end

    // Stage data only advances behind a valid bit, so the last stage holds the previous response.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= accept;
            if (accept) begin
                dat_q[0] <= rsp_data_d;
                err_q[0] <= err_d;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end
        end
    end

`ifdef RAM_ADDR_CHECK_EN
    logic [7:0] err_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && req_we && !in_range && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = vld_q[READ_LATENCY-1];
    assign rsp_rdata = dat_q[READ_LATENCY-1];
    assign rsp_err   = vld_q[READ_LATENCY-1] & err_q[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_sync_pipe.sv
// tb/tb_ram_sync_pipe.sv - directed self-checking bench for ram_sync_pipe
// Honours RAM_ADDR_CHECK_EN for rsp_err and err_count expectations.
module tb_ram_sync_pipe;

`ifdef RAM_ADDR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic        ra, a_valid, a_ready, a_we, a_rsp_valid, a_err, a_busy;
    logic [6:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic [3:0]  a_be;

    logic        rb, b_valid, b_ready, b_we, b_rsp_valid, b_err, b_busy;
    logic [6:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_be;

    ram_sync_pipe #(
        .DATA_W(32), .DEPTH(128), .ADDR_W(7), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_a (
        .clock(clock), .reset(ra), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err), .busy(a_busy)
    );

    ram_sync_pipe #(
        .DATA_W(32), .DEPTH(100), .ADDR_W(7), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
    ) u_b (
        .clock(clock), .reset(rb), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_req(input logic we, input logic [6:0] addr, input logic [31:0] d, input logic [3:0] be);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = d; a_be = be;
    endtask

    task automatic a_idle();
        a_valid = 1'b0; a_we = 1'b0;
    endtask

    task automatic b_req(input logic we, input logic [6:0] addr, input logic [31:0] d, input logic [3:0] be);
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = d; b_be = be;
    endtask

    task automatic b_idle();
        b_valid = 1'b0; b_we = 1'b0;
    endtask

    initial begin
        int n;
        int v;
        logic b_ready1;

        ra = 1'b1; rb = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        b_ready1 = 1'b0;
        tick();
        tick();

        check("a_rst_ready", a_ready, 0);
        check("a_rst_rsp_valid", a_rsp_valid, 0);
        check("a_rst_rdata", a_rdata, 0);
        check("a_rst_err", a_err, 0);
        check("a_rst_busy", a_busy, 1);
        check("b_rst_busy", b_busy, 0);
        check("b_rst_ready", b_ready, 0);

        // Cycle 0 of the sweep starts here; req_ready must rise on cycle 128.
        ra = 1'b0; rb = 1'b0;
        n = 0;
        for (int k = 0; k < 128; k++) begin
            if (a_busy === 1'b1 && a_ready === 1'b0) n++;
            tick();
            if (k == 0) b_ready1 = b_ready;
        end
        check("a_sweep_cycles", n, 128);
        check("a_ready_after_sweep", a_ready, 1);
        check("a_busy_after_sweep", a_busy, 0);
        check("b_ready_one_cycle", b_ready1, 1);

        a_req(1'b0, 7'd5, 32'h0, 4'h0);
        tick(); a_idle();
        check("a_rd5_early", a_rsp_valid, 0);
        tick();
        check("a_rd5_valid", a_rsp_valid, 1);
        check("a_rd5_data", a_rdata, 32'h0);
        tick();
        check("a_rd5_pulse_end", a_rsp_valid, 0);

        a_req(1'b1, 7'd3, 32'hDEADBEEF, 4'hF);
        tick(); a_req(1'b0, 7'd3, 32'h0, 4'h0);
        check("a_wr3_early", a_rsp_valid, 0);
        tick(); a_idle();
        check("a_wr3_valid", a_rsp_valid, 1);
        check("a_wr3_data", a_rdata, 32'hDEADBEEF);
        tick();
        check("a_raw3_valid", a_rsp_valid, 1);
        check("a_raw3_data", a_rdata, 32'hDEADBEEF);
        tick();
        check("a_raw3_pulse_end", a_rsp_valid, 0);
        check("a_hold_data", a_rdata, 32'hDEADBEEF);

        a_req(1'b1, 7'd3, 32'h11223344, 4'b0101);
        tick(); a_req(1'b0, 7'd3, 32'h0, 4'h0);
        tick(); a_idle();
        check("a_be_wr_data", a_rdata, 32'hDE22BE44);
        tick();
        check("a_be_rd_valid", a_rsp_valid, 1);
        check("a_be_rd_data", a_rdata, 32'hDE22BE44);

        a_req(1'b1, 7'd3, 32'h00000000, 4'h0);
        tick(); a_req(1'b0, 7'd3, 32'h0, 4'h0);
        tick(); a_idle();
        check("a_be0_wr_valid", a_rsp_valid, 1);
        check("a_be0_wr_data", a_rdata, 32'hDE22BE44);
        tick();
        check("a_be0_rd_data", a_rdata, 32'hDE22BE44);

        for (int i = 0; i < 8; i++) begin
            a_req(1'b1, 7'(i), 32'(i * 3), 4'hF);
            tick();
        end
        a_idle();
        tick(); tick(); tick();

        for (int t = 0; t < 10; t++) begin
            if (t < 8) a_req(1'b0, 7'(t), 32'h0, 4'h0);
            else a_idle();
            tick();
            if (t >= 1 && t <= 8) begin
                check($sformatf("a_b2b_valid_%0d", t - 1), a_rsp_valid, 1);
                check($sformatf("a_b2b_data_%0d", t - 1), a_rdata, 32'((t - 1) * 3));
            end else begin
                check($sformatf("a_b2b_idle_%0d", t), a_rsp_valid, 0);
            end
        end
        a_idle();

        a_req(1'b0, 7'd1, 32'h0, 4'h0);
        tick(); a_idle();
        ra = 1'b1;
        tick();
        check("a_midrst_drop", a_rsp_valid, 0);
        check("a_midrst_rdata", a_rdata, 0);
        ra = 1'b0;
        n = 0; v = 0;
        for (int k = 0; k < 128; k++) begin
            if (a_busy === 1'b1 && a_ready === 1'b0) n++;
            if (a_rsp_valid !== 1'b0) v++;
            tick();
        end
        check("a_resweep_cycles", n, 128);
        check("a_resweep_no_rsp", v, 0);
        check("a_resweep_ready", a_ready, 1);
        a_req(1'b0, 7'd1, 32'h0, 4'h0);
        tick(); a_idle();
        tick();
        check("a_resweep_rd1", a_rdata, 32'h0);

        b_req(1'b1, 7'd20, 32'h12345678, 4'hF);
        tick(); b_idle();
        check("b_wr20_valid", b_rsp_valid, 1);
        check("b_wr20_data", b_rdata, 32'h12345678);
        check("b_wr20_err", b_err, 0);
        tick();
        check("b_wr20_pulse_end", b_rsp_valid, 0);

        b_req(1'b1, 7'd120, 32'hFFFFFFFF, 4'hF);
        tick(); b_idle();
        check("b_wr120_valid", b_rsp_valid, 1);
        check("b_wr120_data", b_rdata, 32'h0);
        check("b_wr120_err", b_err, EXP_ERR);
`ifdef RAM_ADDR_CHECK_EN
        check("b_err_count_1", u_b.err_count, 1);
`endif
        b_req(1'b0, 7'd120, 32'h0, 4'h0);
        tick();
        check("b_rd120_data", b_rdata, 32'h0);
        check("b_rd120_err", b_err, EXP_ERR);
        b_req(1'b0, 7'd20, 32'h0, 4'h0);
        tick(); b_idle();
        check("b_rd20_data", b_rdata, 32'h12345678);
        check("b_rd20_err", b_err, 0);

        b_req(1'b1, 7'd99, 32'hCAFEF00D, 4'hF);
        tick(); b_req(1'b1, 7'd100, 32'h00000001, 4'hF);
        check("b_wr99_data", b_rdata, 32'hCAFEF00D);
        tick(); b_req(1'b0, 7'd99, 32'h0, 4'h0);
        check("b_wr100_data", b_rdata, 32'h0);
        check("b_wr100_err", b_err, EXP_ERR);
        tick(); b_idle();
        check("b_rd99_data", b_rdata, 32'hCAFEF00D);
        check("b_rd99_err", b_err, 0);
`ifdef RAM_ADDR_CHECK_EN
        check("b_err_count_2", u_b.err_count, 2);
`endif

        b_req(1'b1, 7'd20, 32'h0, 4'hF);
        rb = 1'b1;
        tick();
        rb = 1'b0; b_idle();
        check("b_rstwr_no_rsp", b_rsp_valid, 0);
        check("b_rstwr_ready_low", b_ready, 0);
        check("b_rstwr_busy", b_busy, 0);
        tick();
        check("b_rstwr_ready_high", b_ready, 1);
        b_req(1'b0, 7'd20, 32'h0, 4'h0);
        tick(); b_idle();
        check("b_rstwr_survive", b_rdata, 32'h12345678);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
